shift_sequencer8: RTL and testbench
===================================

Name: shift_sequencer8

Overview:
- Command-driven controller for the 8-bit shift register: accepts {op, amount, data} over a valid/ready handshake and drives the register's parallel-load, rotate-direction and logical-shift controls.
- Counts out the requested shift cycles, then presents the register contents as a result under a second handshake.
- The register has no hold mode, so the controller holds its contents by parallel-loading its own output back when idle.
- Sits between a host/bus FSM and the shift-register datapath.

Parameters:
- WIDTH, 8, data width; must match the shift register.
- AMT_W, 3, width of the shift-amount field; supports 0..2^AMT_W-1 shifts.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 ROR, 01 ROL, 10 LSR (zero fill at MSB), 11 LOAD-only.
- cmd_amount  in  AMT_W  number of single-bit shifts.
- cmd_data  in  WIDTH  value to load before shifting.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- result_data  out  WIDTH  equals sr_q while result_valid is high.
- sr_q  in  WIDTH  shift register Q_out.
- sr_data  out  WIDTH  to shift register DATA_IN.
- sr_loadn  out  1  to ParallelLoadn; 0 means load.
- sr_rotate_right  out  1  to RotateRight.
- sr_ls_right  out  1  to LSRight.

Behaviour:
- States: IDLE, SHIFT, DONE. Registered state, op and remaining count. Control outputs are combinational from state and the registered op.
- Reset (async, while asserted):
  - State IDLE, count 0.
  - cmd_ready=0, result_valid=0.
  - sr_loadn=0, sr_data=sr_q, sr_rotate_right=0, sr_ls_right=0.
- IDLE:
  - cmd_ready=1, sr_loadn=0.
  - sr_data = cmd_valid ? cmd_data : sr_q, so the load happens at the handshake edge.
  - On handshake: latch op and amount. Next state is SHIFT if amount!=0 and op!=LOAD, else DONE.
- SHIFT:
  - sr_loadn=1.
  - sr_rotate_right=1 for ROR/LSR, 0 for ROL.
  - sr_ls_right=1 only for LSR.
  - Count decrements each cycle; when it reaches 1 at an edge, next state is DONE. Exactly `amount` shift edges occur.
- DONE:
  - Hold the register (sr_loadn=0, sr_data=sr_q).
  - result_valid=1, result_data=sr_q.
  - On result_ready, return to IDLE. cmd_ready stays 0 in DONE.
- Latency: handshake in cycle 0 gives result_valid from cycle amount+1 (LOAD and amount=0: cycle 1).
- Throughput: one command per amount+2 cycles minimum (IDLE between commands).
- Boundaries:
  - amount = 2^AMT_W-1 performs the full count; no wrap.
  - cmd_valid in SHIFT or DONE is ignored and must be held by the source.
  - result_ready with result_valid low has no effect.
  - Reset mid-SHIFT aborts immediately to IDLE; the register's own reset clears its data.

Optional Feature:
- Macro SHIFT_SEQ_ABORT_EN.
- With the macro: extra input abort (1 bit) and output result_aborted (1 bit).
  - abort high in SHIFT forces DONE at the next edge; no shift occurs on that edge (sr_loadn=0, sr_data=sr_q).
  - result_aborted=1 for that result and clears when the result is accepted.
  - abort is ignored in IDLE and DONE.
- Without the macro: neither port exists, and every command runs to completion.

Decomposition:
- Package/include shift_seq_pkg:
  - op encodings OP_ROR, OP_ROL, OP_LSR, OP_LOAD.
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE.
- One natural sub-module, shift_amount_counter: a loadable down-counter with a terminal-count flag, parameterised by AMT_W.

Test Plan:
- ROR, amount 1, data 0x81 -> result_valid in cycle 2, result_data 0xC0.
- ROL, amount 1, data 0x81 -> result 0x03. ROL, amount 7, data 0x01 -> result 0x80 in cycle 8.
- LSR, amount 3, data 0xF0 -> result 0x1E. LSR, amount 7, data 0xFF -> result 0x01.
- LOAD-only, data 0x5A, amount 5 -> result 0x5A in cycle 1, no shift edges. Hold result_ready low 6 cycles -> result_data and sr_q stay 0x5A, and cmd_ready stays 0.
- Assert reset mid-SHIFT (ROR, amount 6, cycle 3) -> cmd_ready=0 and result_valid=0 asynchronously; IDLE after release; a next command 0x33 LSR 1 gives 0x19.
- With SHIFT_SEQ_ABORT_EN: ROR, amount 6, data 0x01, abort in cycle 3 -> result 0x40 (2 shifts), result_aborted=1.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift-register sequencer.
// Contents: command op codes, controller state codes, and a helper
// that decides whether a command needs any shift cycles.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_ROR  = 2'b00,
    OP_ROL  = 2'b01,
    OP_LSR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // A command shifts only if it is not LOAD-only and asks for at least one step.
  function automatic logic needs_shift(input op_e op, input logic nonzero_amount);
    return nonzero_amount && (op != OP_LOAD);
  endfunction

endpackage

// File: rtl/shift_amount_counter.sv
// Loadable down-counter for the remaining shift steps.
// Ports: clock/reset (async active-high), load + load_value set the count,
// dec counts down by one (saturating at zero), tc flags the final step (count == 1).
module shift_amount_counter #(
  parameter int unsigned AMT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [AMT_W-1:0] load_value,
  input  logic             dec,
  output logic             tc
);

  logic [AMT_W-1:0] count_q;

  // Remaining-step register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - AMT_W'(1);
    end
  end

  assign tc = (count_q == AMT_W'(1));

endmodule

// File: rtl/shift_sequencer8.sv
// Command-driven controller for an external 8-bit shift register.
// Accepts {op, amount, data} on cmd_*, loads the register, runs `amount`
// shift cycles, then offers the register contents on result_*.
// While idle or done the register is held by loading its own output back.
// Ports: clock, reset (async active-high); cmd_valid/cmd_ready/cmd_op/
// cmd_amount/cmd_data; result_valid/result_ready/result_data; sr_q from the
// register; sr_data/sr_loadn/sr_rotate_right/sr_ls_right to the register.
// Optional build macro SHIFT_SEQ_ABORT_EN adds input abort and output
// result_aborted: abort during a shift stops it at the next edge.
module shift_sequencer8
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amount,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result_data,
  input  logic [WIDTH-1:0] sr_q,
  output logic [WIDTH-1:0] sr_data,
  output logic             sr_loadn,
  output logic             sr_rotate_right,
  output logic             sr_ls_right
`ifdef SHIFT_SEQ_ABORT_EN
  ,
  input  logic             abort,
  output logic             result_aborted
`endif
);

  state_e state_q, state_d;
  op_e    op_q;
  logic   cmd_fire_c;
  logic   abort_hit_c;
  logic   cnt_tc;

  assign cmd_fire_c = cmd_ready && cmd_valid;

`ifdef SHIFT_SEQ_ABORT_EN
  logic aborted_q;

  assign abort_hit_c = abort && (state_q == ST_SHIFT);

  // Marks a result produced by an abort; cleared when that result is taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aborted_q <= 1'b0;
    end else if (abort_hit_c) begin
      aborted_q <= 1'b1;
    end else if ((state_q == ST_DONE) && result_ready) begin
      aborted_q <= 1'b0;
    end
  end

  assign result_aborted = aborted_q;
`else
  assign abort_hit_c = 1'b0;
`endif

  shift_amount_counter #(.AMT_W(AMT_W)) u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cmd_fire_c),
    .load_value (cmd_amount),
    .dec        ((state_q == ST_SHIFT) && !abort_hit_c),
    .tc         (cnt_tc)
  );

  // State and latched op.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ROR;
    end else begin
      state_q <= state_d;
      if (cmd_fire_c) begin
        op_q <= op_e'(cmd_op);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire_c) begin
          state_d = needs_shift(op_e'(cmd_op), cmd_amount != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (abort_hit_c || cnt_tc) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register controls and handshakes; reset forces the hold/not-ready values.
  always_comb begin
    cmd_ready       = 1'b0;
    result_valid    = 1'b0;
    sr_loadn        = 1'b0;
    sr_data         = sr_q;
    sr_rotate_right = 1'b0;
    sr_ls_right     = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            sr_data = cmd_data;
          end
        end
        ST_SHIFT: begin
          if (!abort_hit_c) begin
            sr_loadn        = 1'b1;
            sr_rotate_right = (op_q != OP_ROL);
            sr_ls_right     = (op_q == OP_LSR);
          end
        end
        ST_DONE: begin
          result_valid = 1'b1;
        end
        default: begin
          cmd_ready = 1'b0;
        end
      endcase
    end
  end

  assign result_data = sr_q;

endmodule

// File: tb/tb_shift_sequencer8.sv
// Bench for shift_sequencer8: models the external shift register, drives
// directed and random commands, and compares result value, latency and
// shift-edge count against an arithmetic reference.
module tb_shift_sequencer8;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_amount;
  logic [7:0] cmd_data;
  logic       result_valid;
  logic       result_ready;
  logic [7:0] result_data;
  logic [7:0] sr_q;
  logic [7:0] sr_data;
  logic       sr_loadn;
  logic       sr_rotate_right;
  logic       sr_ls_right;
`ifdef SHIFT_SEQ_ABORT_EN
  logic       abort;
  logic       result_aborted;
`endif

  int n_vec = 0;
  int n_err = 0;
  int shift_edges = 0;

  shift_sequencer8 #(.WIDTH(8), .AMT_W(3)) dut (
    .clock           (clock),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_amount      (cmd_amount),
    .cmd_data        (cmd_data),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_data     (result_data),
    .sr_q            (sr_q),
    .sr_data         (sr_data),
    .sr_loadn        (sr_loadn),
    .sr_rotate_right (sr_rotate_right),
    .sr_ls_right     (sr_ls_right)
`ifdef SHIFT_SEQ_ABORT_EN
    ,
    .abort           (abort),
    .result_aborted  (result_aborted)
`endif
  );

  always #5 clock = ~clock;

  // External shift register: parallel load, rotate left/right, logical right.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_q <= 8'h00;
    end else if (!sr_loadn) begin
      sr_q <= sr_data;
    end else if (sr_rotate_right) begin
      sr_q <= sr_ls_right ? {1'b0, sr_q[7:1]} : {sr_q[0], sr_q[7:1]};
    end else begin
      sr_q <= {sr_q[6:0], sr_q[7]};
    end
  end

  // Counts edges on which the register actually shifts.
  always @(posedge clock) begin
    if (!reset && sr_loadn) begin
      shift_edges <= shift_edges + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Result of n single-bit steps of op on d, by whole-word arithmetic.
  function automatic logic [7:0] ref_result(input logic [1:0] op, input int n, input logic [7:0] d);
    logic [15:0] dd;
    dd = {d, d};
    case (op)
      2'b00:   return 8'(dd >> n);
      2'b01:   return 8'((dd << n) >> 8);
      2'b10:   return 8'(d >> n);
      default: return d;
    endcase
  endfunction

  // One full transaction; abort_cyc < 0 means no abort.
  task automatic run_cmd(input logic [1:0] op, input int amt, input logic [7:0] data,
                         input int abort_cyc, input int hold);
    int n_eff, exp_lat, cyc, start_edges;
    logic exp_ab;
    logic [7:0] exp_r;
    n_eff  = (op == 2'b11) ? 0 : amt;
    exp_ab = 1'b0;
    if (abort_cyc >= 1 && abort_cyc <= n_eff) begin
      n_eff  = abort_cyc - 1;
      exp_ab = 1'b1;
    end
    exp_lat = exp_ab ? abort_cyc + 1 : ((n_eff == 0) ? 1 : n_eff + 1);
    exp_r   = ref_result(op, n_eff, data);

    @(negedge clock);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_amount = 3'(amt);
    cmd_data   = data;
    check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    start_edges = shift_edges;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      // Traffic on cmd_* outside IDLE must be ignored.
      cmd_valid  = 1'($urandom);
      cmd_op     = 2'($urandom);
      cmd_amount = 3'($urandom);
      cmd_data   = 8'($urandom);
`ifdef SHIFT_SEQ_ABORT_EN
      abort = (cyc == abort_cyc);
`endif
    end while (!result_valid && cyc < 20);
`ifdef SHIFT_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    check_eq("latency", 32'(cyc), 32'(exp_lat));
    check_eq("result_data", 32'(result_data), 32'(exp_r));
    check_eq("shift_edges", 32'(shift_edges - start_edges), 32'(n_eff));
`ifdef SHIFT_SEQ_ABORT_EN
    check_eq("result_aborted", 32'(result_aborted), 32'(exp_ab));
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      cmd_valid = 1'($urandom);
      cmd_data  = 8'($urandom);
      check_eq("hold_valid", 32'(result_valid), 32'd1);
      check_eq("hold_data", 32'(result_data), 32'(exp_r));
      check_eq("hold_sr_q", 32'(sr_q), 32'(exp_r));
      check_eq("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    result_ready = 1'b1;
    cmd_valid    = 1'b0;
    @(negedge clock);
    result_ready = 1'b0;
    check_eq("accept_valid", 32'(result_valid), 32'd0);
    check_eq("accept_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("idle_hold_sr_q", 32'(sr_q), 32'(exp_r));
`ifdef SHIFT_SEQ_ABORT_EN
    check_eq("aborted_clear", 32'(result_aborted), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_op       = 2'b00;
    cmd_amount   = 3'd0;
    cmd_data     = 8'h00;
    result_ready = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
    abort        = 1'b0;
`endif
    #1;
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_result_valid", 32'(result_valid), 32'd0);
    check_eq("rst_sr_loadn", 32'(sr_loadn), 32'd0);
    check_eq("rst_rotate_right", 32'(sr_rotate_right), 32'd0);
    check_eq("rst_ls_right", 32'(sr_ls_right), 32'd0);
    check_eq("rst_sr_data", 32'(sr_data), 32'(sr_q));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // result_ready without a pending result does nothing.
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    check_eq("stray_ready_valid", 32'(result_valid), 32'd0);
    check_eq("stray_ready_cmd_ready", 32'(cmd_ready), 32'd1);

    run_cmd(2'b00, 1, 8'h81, -1, 0);
    run_cmd(2'b01, 1, 8'h81, -1, 1);
    run_cmd(2'b01, 7, 8'h01, -1, 0);
    run_cmd(2'b10, 3, 8'hF0, -1, 2);
    run_cmd(2'b10, 7, 8'hFF, -1, 0);
    run_cmd(2'b11, 5, 8'h5A, -1, 6);
    run_cmd(2'b00, 0, 8'hC3, -1, 0);

    // Reset in the middle of a shift.
    @(negedge clock);
    cmd_valid  = 1'b1;
    cmd_op     = 2'b00;
    cmd_amount = 3'd6;
    cmd_data   = 8'hA5;
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("midrst_result_valid", 32'(result_valid), 32'd0);
    check_eq("midrst_sr_loadn", 32'(sr_loadn), 32'd0);
    check_eq("midrst_sr_q", 32'(sr_q), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("midrst_idle_ready", 32'(cmd_ready), 32'd1);
    check_eq("midrst_idle_valid", 32'(result_valid), 32'd0);
    run_cmd(2'b10, 1, 8'h33, -1, 0);

`ifdef SHIFT_SEQ_ABORT_EN
    run_cmd(2'b00, 6, 8'h01, 3, 1);
    run_cmd(2'b01, 4, 8'h11, 1, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      int ab;
      ab = -1;
`ifdef SHIFT_SEQ_ABORT_EN
      if ($urandom_range(0, 3) == 0) ab = int'($urandom_range(1, 8));
`endif
      run_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 8'($urandom),
              ab, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
